// File: rtl/issue_controller.sv
// Issue/hazard controller between decode and execute.
// Accepts one decoded micro-op per cycle. It stalls the op on RAW/WAW hazards
// against outstanding long-latency results (loads, CSR reads). It also caps
// the number of outstanding load/store ops and serialises CSR ops.
//
// Handshake: a micro-op moves only in a cycle where dec_valid and dec_ready
// are both high. dec_ready may depend on dec_valid's payload but never on
// dec_valid itself. issue_fire additionally requires that no flush kills the
// decode slot in that cycle.
module issue_controller #(
  parameter int MAX_LDST = 2,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [4:0]       dec_rs1_addr,
  input  logic             dec_rs1_used,
  input  logic [4:0]       dec_rs2_addr,
  input  logic             dec_rs2_used,
  input  logic [4:0]       dec_rd_addr,
  input  logic             dec_rd_en,
  input  logic             dec_ld_st_en,
  input  logic             dec_csr_en,
  input  logic             flush,
  output logic             issue_fire,
  input  logic             lsu_done,
  input  logic             csr_done,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd_addr,
  output logic [31:0]      pending,
  output logic [CNT_W-1:0] ldst_cnt,
  output logic             busy
);

  // RUN: normal issue. DRAIN: CSR op waits for the pipe to empty.
  // CSR_WAIT: CSR op in flight; nothing else issues until it completes.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_CSR_WAIT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pending_q, pending_d;
  logic [CNT_W-1:0] ldst_cnt_q, ldst_cnt_d;
  logic             busy_q, busy_d;

  logic hazard;
  logic ldst_full;
  logic ldst_inc;
  logic ldst_dec;

  // Hazard detection against registered scoreboard only (no write-back bypass).
  always_comb begin
    hazard    = (dec_rs1_used && (dec_rs1_addr != 5'd0) && pending_q[dec_rs1_addr]) ||
                (dec_rs2_used && (dec_rs2_addr != 5'd0) && pending_q[dec_rs2_addr]) ||
                (dec_rd_en    && (dec_rd_addr  != 5'd0) && pending_q[dec_rd_addr]);
    ldst_full = dec_ld_st_en && (ldst_cnt_q == CNT_W'(MAX_LDST));
  end

  // FSM next state and the ready decision for the current decode slot.
  always_comb begin
    state_d   = state_q;
    dec_ready = 1'b0;
    case (state_q)
      ST_RUN: begin
        dec_ready = !hazard && !ldst_full && !dec_csr_en;
        if (dec_valid && dec_csr_en && !flush) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        dec_ready = (pending_q == 32'd0) && (ldst_cnt_q == '0);
        if (flush)                       state_d = ST_RUN;
        else if (dec_valid && dec_ready) state_d = ST_CSR_WAIT;
      end
      ST_CSR_WAIT: begin
        // The CSR op is already committed, so flush has no effect here.
        dec_ready = 1'b0;
        if (csr_done) state_d = ST_RUN;
      end
      default: begin
        dec_ready = 1'b0;
        state_d   = ST_RUN;
      end
    endcase
    busy_d = (state_d != ST_RUN);
  end

  assign issue_fire = dec_valid && dec_ready && !flush;

  // Scoreboard and outstanding load/store counter updates.
  always_comb begin
    pending_d = pending_q;
    if (wb_valid) pending_d[wb_rd_addr] = 1'b0;
    // A set applied after the clear lets a same-cycle set win.
    if (issue_fire && dec_rd_en && (dec_rd_addr != 5'd0) && (dec_ld_st_en || dec_csr_en))
      pending_d[dec_rd_addr] = 1'b1;
    pending_d[0] = 1'b0;

    ldst_inc = issue_fire && dec_ld_st_en;
    // A completion with nothing outstanding is dropped (saturate at zero).
    ldst_dec = lsu_done && (ldst_cnt_q != '0);
    case ({ldst_inc, ldst_dec})
      2'b10:   ldst_cnt_d = ldst_cnt_q + CNT_W'(1);
      2'b01:   ldst_cnt_d = ldst_cnt_q - CNT_W'(1);
      default: ldst_cnt_d = ldst_cnt_q;
    endcase
  end

  // Single state register for FSM, scoreboard, counter and registered busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pending_q  <= 32'd0;
      ldst_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      ldst_cnt_q <= ldst_cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign pending  = pending_q;
  assign ldst_cnt = ldst_cnt_q;
  assign busy     = busy_q;

  // A load/store completion must never arrive with nothing outstanding.
  lsu_underflow_a: assert property (@(posedge clk) disable iff (reset)
    !(lsu_done && (ldst_cnt_q == '0)))
    else $error("lsu_done received with no outstanding load/store");

endmodule

// File: tb/tb_issue_controller.sv
// Bench for issue_controller: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_issue_controller;
  localparam int MAX_LDST = 2;
  localparam int CNT_W    = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             dec_valid;
  logic             dec_ready;
  logic [4:0]       dec_rs1_addr;
  logic             dec_rs1_used;
  logic [4:0]       dec_rs2_addr;
  logic             dec_rs2_used;
  logic [4:0]       dec_rd_addr;
  logic             dec_rd_en;
  logic             dec_ld_st_en;
  logic             dec_csr_en;
  logic             flush;
  logic             issue_fire;
  logic             lsu_done;
  logic             csr_done;
  logic             wb_valid;
  logic [4:0]       wb_rd_addr;
  logic [31:0]      pending;
  logic [CNT_W-1:0] ldst_cnt;
  logic             busy;

  issue_controller #(.MAX_LDST(MAX_LDST), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1_addr(dec_rs1_addr), .dec_rs1_used(dec_rs1_used),
    .dec_rs2_addr(dec_rs2_addr), .dec_rs2_used(dec_rs2_used),
    .dec_rd_addr(dec_rd_addr), .dec_rd_en(dec_rd_en),
    .dec_ld_st_en(dec_ld_st_en), .dec_csr_en(dec_csr_en),
    .flush(flush), .issue_fire(issue_fire),
    .lsu_done(lsu_done), .csr_done(csr_done),
    .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr),
    .pending(pending), .ldst_cnt(ldst_cnt), .busy(busy)
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_mode: 0 free issue, 1 CSR waiting for pipe to empty, 2 CSR in flight.
  int          m_mode = 0;
  logic [31:0] m_pend = 32'd0;
  int          m_cnt  = 0;

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin : cmp
    logic exp_hz, exp_rdy, exp_fire;
    int   nmode, ncnt;
    logic [31:0] npend;
    if (chk_on) begin
      exp_hz = (dec_rs1_used && dec_rs1_addr != 0 && m_pend[dec_rs1_addr]) ||
               (dec_rs2_used && dec_rs2_addr != 0 && m_pend[dec_rs2_addr]) ||
               (dec_rd_en    && dec_rd_addr  != 0 && m_pend[dec_rd_addr]);
      if (m_mode == 0)
        exp_rdy = !exp_hz && !(dec_ld_st_en && m_cnt == MAX_LDST) && !dec_csr_en;
      else if (m_mode == 1)
        exp_rdy = (m_pend == 32'd0) && (m_cnt == 0);
      else
        exp_rdy = 1'b0;
      exp_fire = dec_valid && exp_rdy && !flush;

      check("m_dec_ready", {31'd0, dec_ready}, {31'd0, exp_rdy});
      check("m_issue_fire", {31'd0, issue_fire}, {31'd0, exp_fire});
      check("m_pending", pending, m_pend);
      check("m_ldst_cnt", 32'(ldst_cnt), 32'(m_cnt));
      check("m_busy", {31'd0, busy}, {31'd0, (m_mode != 0)});

      nmode = m_mode;
      if (m_mode == 0 && dec_valid && dec_csr_en && !flush) nmode = 1;
      if (m_mode == 1) nmode = flush ? 0 : (exp_fire ? 2 : 1);
      if (m_mode == 2 && csr_done) nmode = 0;

      npend = m_pend;
      if (wb_valid) npend[wb_rd_addr] = 1'b0;
      if (exp_fire && dec_rd_en && dec_rd_addr != 0 && (dec_ld_st_en || dec_csr_en))
        npend[dec_rd_addr] = 1'b1;

      ncnt = m_cnt + ((exp_fire && dec_ld_st_en) ? 1 : 0);
      if (lsu_done && m_cnt > 0) ncnt = ncnt - 1;

      if (reset) begin
        nmode = 0; npend = 32'd0; ncnt = 0;
      end
      m_mode = nmode;
      m_pend = npend;
      m_cnt  = ncnt;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clr();
    dec_valid = 0; dec_rs1_addr = 0; dec_rs1_used = 0; dec_rs2_addr = 0; dec_rs2_used = 0;
    dec_rd_addr = 0; dec_rd_en = 0; dec_ld_st_en = 0; dec_csr_en = 0;
    flush = 0; lsu_done = 0; csr_done = 0; wb_valid = 0; wb_rd_addr = 0;
  endtask

  task automatic set_op(input logic v, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2,
                        input logic [4:0] rd, input logic rde,
                        input logic ls, input logic cs);
    dec_valid = v; dec_rs1_addr = r1; dec_rs1_used = u1; dec_rs2_addr = r2; dec_rs2_used = u2;
    dec_rd_addr = rd; dec_rd_en = rde; dec_ld_st_en = ls; dec_csr_en = cs;
  endtask

  task automatic wb(input logic [4:0] a);
    wb_valid = 1; wb_rd_addr = a;
  endtask

  // Sample point: just after the falling edge (after the compare process).
  task automatic go();
    @(negedge clk); #1;
  endtask
  // Drive point: just after the rising edge.
  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic rand_op();
    int k;
    k = $urandom_range(0, 9);
    set_op(($urandom_range(0, 3) != 0),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)), 1'b0, 1'b0, 1'b0);
    if (k <= 4)      dec_rd_en = 1;                       // ALU
    else if (k <= 6) begin dec_rd_en = 1; dec_ld_st_en = 1; end // load
    else if (k == 7) dec_ld_st_en = 1;                    // store
    else if (k == 8) begin dec_csr_en = 1; dec_rd_en = 1'($urandom_range(0, 1)); end
    // k == 9: branch, no rd
  endtask

  logic held;

  initial begin
    clr();
    reset = 1;
    @(posedge clk); #1;
    chk_on = 1;
    nxt();
    reset = 0;
    go();
    check("rst_ready", {31'd0, dec_ready}, 32'd1);
    check("rst_fire", {31'd0, issue_fire}, 32'd0);
    check("rst_pending", pending, 32'd0);
    check("rst_cnt", 32'(ldst_cnt), 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    nxt();

    // Load x5, then dependent add x6,x5,x1 waits for write-back.
    set_op(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1, 0);
    go(); check("ld5_fire", {31'd0, issue_fire}, 32'd1); nxt();
    set_op(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0);
    go();
    check("ld5_pending", pending, 32'h20);
    check("ld5_cnt", 32'(ldst_cnt), 32'd1);
    check("raw_stall", {31'd0, dec_ready}, 32'd0);
    nxt();
    wb(5'd5);
    go(); check("raw_no_bypass", {31'd0, dec_ready}, 32'd0); nxt();
    wb_valid = 0;
    go();
    check("raw_issue_after_wb", {31'd0, issue_fire}, 32'd1);
    check("raw_pending_clear", pending, 32'd0);
    nxt();
    clr(); lsu_done = 1; go(); nxt();
    clr(); go(); check("ld5_cnt_back", 32'(ldst_cnt), 32'd0); nxt();

    // Three back-to-back loads against a limit of two.
    set_op(1, 0, 0, 0, 0, 5'd1, 1, 1, 0); go(); nxt();
    set_op(1, 0, 0, 0, 0, 5'd2, 1, 1, 0); go(); nxt();
    set_op(1, 0, 0, 0, 0, 5'd3, 1, 1, 0);
    go();
    check("ldfull_stall", {31'd0, dec_ready}, 32'd0);
    check("ldfull_cnt", 32'(ldst_cnt), 32'd2);
    nxt();
    lsu_done = 1;
    go(); check("ldfull_no_credit", {31'd0, dec_ready}, 32'd0); nxt();
    lsu_done = 0;
    go();
    check("ldfull_issue", {31'd0, issue_fire}, 32'd1);
    check("ldfull_cnt_dip", 32'(ldst_cnt), 32'd1);
    nxt();
    clr();
    go();
    check("ldfull_cnt_after", 32'(ldst_cnt), 32'd2);
    check("ldfull_pending", pending, 32'h0000000e);
    nxt();
    lsu_done = 1; wb(5'd1); go(); nxt();
    wb(5'd2); go(); nxt();
    lsu_done = 0; wb(5'd3); go(); nxt();
    clr(); go(); check("ldfull_drained", pending | 32'(ldst_cnt), 32'd0); nxt();

    // Same-cycle set and clear of x7: set wins.
    set_op(1, 0, 0, 0, 0, 5'd7, 1, 1, 0); wb(5'd7);
    go(); nxt();
    clr(); go(); check("set_wins", pending, 32'h80); nxt();
    wb(5'd7); lsu_done = 1; go(); nxt();
    clr();

    // CSR op behind an outstanding load.
    set_op(1, 0, 0, 0, 0, 5'd9, 1, 1, 0); go(); nxt();
    set_op(1, 5'd3, 1, 5'd0, 0, 5'd10, 1, 0, 1);
    go();
    check("csr_no_run_issue", {31'd0, issue_fire}, 32'd0);
    check("csr_busy_run", {31'd0, busy}, 32'd0);
    nxt();
    go();
    check("csr_drain_busy", {31'd0, busy}, 32'd1);
    check("csr_drain_wait", {31'd0, dec_ready}, 32'd0);
    nxt();
    lsu_done = 1; go(); nxt();
    lsu_done = 0;
    go(); check("csr_wait_wb", {31'd0, dec_ready}, 32'd0); nxt();
    wb(5'd9); go(); check("csr_wb_no_bypass", {31'd0, dec_ready}, 32'd0); nxt();
    wb_valid = 0;
    go();
    check("csr_issue", {31'd0, issue_fire}, 32'd1);
    nxt();
    set_op(1, 5'd1, 1, 5'd0, 0, 5'd11, 1, 0, 0);
    go();
    check("csrw_ready", {31'd0, dec_ready}, 32'd0);
    check("csrw_busy", {31'd0, busy}, 32'd1);
    check("csrw_pending", pending, 32'h400);
    nxt();
    csr_done = 1; go(); nxt();
    csr_done = 0;
    go();
    check("csr_back_run", {31'd0, busy}, 32'd0);
    check("alu_after_csr", {31'd0, issue_fire}, 32'd1);
    nxt();
    clr(); wb(5'd10); go(); nxt();
    clr();

    // Flush kills an issuable op; flush in DRAIN returns to RUN.
    set_op(1, 5'd1, 1, 5'd2, 1, 5'd12, 1, 0, 0); flush = 1;
    go();
    check("flush_fire", {31'd0, issue_fire}, 32'd0);
    check("flush_ready", {31'd0, dec_ready}, 32'd1);
    nxt();
    clr(); go(); check("flush_state", pending | 32'(ldst_cnt), 32'd0); nxt();
    set_op(1, 0, 0, 0, 0, 5'd0, 0, 0, 1); go(); nxt();
    flush = 1;
    go(); check("drain_flush_fire", {31'd0, issue_fire}, 32'd0); nxt();
    clr(); go(); check("drain_flush_run", {31'd0, busy}, 32'd0); nxt();

    // Load to x0, then reset with loads outstanding.
    set_op(1, 0, 0, 0, 0, 5'd0, 1, 1, 0);
    go(); check("x0_fire", {31'd0, issue_fire}, 32'd1); nxt();
    clr(); go();
    check("x0_pending", pending, 32'd0);
    check("x0_cnt", 32'(ldst_cnt), 32'd1);
    nxt();
    set_op(1, 0, 0, 0, 0, 5'd4, 1, 1, 0); go(); nxt();
    clr(); reset = 1; go(); nxt();
    reset = 0; go();
    check("rst_run_cnt", 32'(ldst_cnt), 32'd0);
    check("rst_run_pend", pending, 32'd0);
    nxt();

    // Reset while a CSR op is in flight.
    set_op(1, 0, 0, 0, 0, 5'd13, 1, 0, 1); go(); nxt();
    go(); check("csr2_issue", {31'd0, issue_fire}, 32'd1); nxt();
    clr(); go();
    check("csr2_busy", {31'd0, busy}, 32'd1);
    check("csr2_pending", pending, 32'h2000);
    nxt();
    reset = 1; go(); nxt();
    reset = 0; go();
    check("rst_csrw_busy", {31'd0, busy}, 32'd0);
    check("rst_csrw_pend", pending, 32'd0);
    nxt();

    // Randomized traffic; the compare process checks every cycle.
    held = 0;
    for (int c = 0; c < 4000; c++) begin
      flush    = ($urandom_range(0, 9) == 0);
      lsu_done = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
      csr_done = (m_mode == 2) && ($urandom_range(0, 2) == 0);
      reset    = ($urandom_range(0, 499) == 0);
      wb_valid = 0;
      wb_rd_addr = 0;
      if (m_pend != 32'd0 && $urandom_range(0, 2) == 0) begin
        int start;
        bit found;
        start = $urandom_range(0, 31);
        found = 0;
        for (int k = 0; k < 32; k++) begin
          if (!found && m_pend[(start + k) % 32]) begin
            found = 1;
            wb_valid = 1;
            wb_rd_addr = 5'((start + k) % 32);
          end
        end
      end else if ($urandom_range(0, 15) == 0) begin
        wb(5'($urandom_range(0, 31)));
      end
      if (!held) rand_op();
      go();
      held = dec_valid && !issue_fire && !flush && !reset;
      nxt();
    end

    clr(); reset = 0;
    go(); nxt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
